// File: rtl/module_bus_interconnect_pkg.sv
// Shared types and defaults for the single-master bus interconnect.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package bus_pkg;

   // Access sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Default address map: slave k occupies bits [k*ADDR_W +: ADDR_W]
   localparam int DEF_N_SLV   = 6;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 16;

   localparam logic [DEF_N_SLV*DEF_ADDR_W-1:0] DEF_SLV_BASE = {
      32'h0000_2030, 32'h0000_2020, 32'h0000_2010,
      32'h0000_2004, 32'h0000_2000, 32'h0000_1000
   };

   localparam logic [DEF_N_SLV*DEF_ADDR_W-1:0] DEF_SLV_SIZE = {
      32'h0000_0010, 32'h0000_0010, 32'h0000_0010,
      32'h0000_0004, 32'h0000_0004, 32'h0000_0400
   };

   localparam logic [DEF_N_SLV-1:0] DEF_RO_MASK = 6'b000010;

   // Width of a slave index; never narrower than one bit
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/module_bus_interconnect_if.sv
// Master-side and slave-side bus signals of the interconnect.
// Latency: n/a (wires only).
// Backpressure: slave ready_i stalls the access; master waits for ready_o.
interface module_bus_interconnect_if #(
   parameter int N_SLV  = 6,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Upstream master
   logic                    req_i;
   logic                    we_i;
   logic [ADDR_W-1:0]       addr_i;
   logic [DATA_W-1:0]       wdata_i;
   logic [DATA_W-1:0]       rdata_o;
   logic                    ready_o;
   logic                    err_o;

   // Downstream slaves
   logic [N_SLV-1:0]        sel_o;
   logic [N_SLV-1:0]        we_o;
   logic [ADDR_W-1:0]       addr_o;
   logic [DATA_W-1:0]       wdata_o;
   logic [N_SLV*DATA_W-1:0] rdata_i;
   logic [N_SLV-1:0]        ready_i;

   // Interconnect acting as the slave of the upstream master
   modport slave (
      input  req_i, we_i, addr_i, wdata_i,
      output rdata_o, ready_o, err_o
   );

   // Interconnect acting as the master of the downstream slaves
   modport master (
      output sel_o, we_o, addr_o, wdata_o,
      input  rdata_i, ready_i
   );

endinterface

// File: rtl/module_bus_addr_decoder.sv
// Combinational address decode: hit flag, winning slave index, access error.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle from the live master inputs.
module module_bus_addr_decoder
   import bus_pkg::*;
#(
   parameter int                        N_SLV    = DEF_N_SLV,
   parameter int                        ADDR_W   = DEF_ADDR_W,
   parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = DEF_SLV_BASE,
   parameter logic [N_SLV*ADDR_W-1:0]   SLV_SIZE = DEF_SLV_SIZE,
   parameter logic [N_SLV-1:0]          RO_MASK  = DEF_RO_MASK,
   parameter int                        IDX_W    = idx_w(N_SLV)
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              we_i,
   output logic              hit_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              err_o
);

   // Window match per slave; scanning downward lets the lowest index win overlaps
   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      for (int k = N_SLV - 1; k >= 0; k--) begin
         if ((addr_i & ~(SLV_SIZE[k*ADDR_W +: ADDR_W] - ADDR_W'(1)))
               == SLV_BASE[k*ADDR_W +: ADDR_W]) begin
            hit_o = 1'b1;
            idx_o = IDX_W'(k);
         end
      end
   end

   // Unmapped, word-misaligned, or a write aimed at a read-only slave
   always_comb begin
      err_o = 1'b0;
      if (!hit_o || (addr_i[1:0] != 2'b00) || (we_i && RO_MASK[idx_o])) begin
         err_o = 1'b1;
      end
   end

endmodule

// File: rtl/module_bus_interconnect.sv
// Single-master to N-slave bus interconnect with decode, select and response FSM.
// Latency: request to sel_o 1 cycle, to ready_o 2 cycles zero-wait; decode errors respond in 1 cycle.
// Backpressure: waits on the selected slave's ready_i (optional abort via BUS_TIMEOUT_EN).
module module_bus_interconnect
   import bus_pkg::*;
#(
   parameter int                        N_SLV    = DEF_N_SLV,
   parameter int                        ADDR_W   = DEF_ADDR_W,
   parameter int                        DATA_W   = DEF_DATA_W,
   parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = DEF_SLV_BASE,
   parameter logic [N_SLV*ADDR_W-1:0]   SLV_SIZE = DEF_SLV_SIZE,
   parameter logic [N_SLV-1:0]          RO_MASK  = DEF_RO_MASK,
   parameter int                        TIMEOUT  = DEF_TIMEOUT
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   module_bus_interconnect_if.slave    up,
   module_bus_interconnect_if.master   dn
);

   localparam int IDX_W = idx_w(N_SLV);

`ifdef BUS_TIMEOUT_EN
   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
   logic [CNT_W-1:0]            cnt_q, cnt_d;
`endif

   state_e              state_q, state_d;
   logic [N_SLV-1:0]    sel_q, sel_d;
   logic [N_SLV-1:0]    we_q, we_d;
   logic                ready_q, ready_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                wr_q, wr_d;

   logic                dec_hit;
   logic [IDX_W-1:0]    dec_idx;
   logic                dec_err;

   module_bus_addr_decoder #(
      .N_SLV    (N_SLV),
      .ADDR_W   (ADDR_W),
      .SLV_BASE (SLV_BASE),
      .SLV_SIZE (SLV_SIZE),
      .RO_MASK  (RO_MASK),
      .IDX_W    (IDX_W)
   ) u_dec (
      .addr_i (up.addr_i),
      .we_i   (up.we_i),
      .hit_o  (dec_hit),
      .idx_o  (dec_idx),
      .err_o  (dec_err)
   );

   // Next state and next register values; ready/err are single-cycle strobes
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      we_d    = we_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      idx_d   = idx_q;
      wr_d    = wr_q;
`ifdef BUS_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (up.req_i) begin
               if (dec_hit && !dec_err) begin
                  // Latch the whole request so master changes cannot disturb it
                  state_d = ST_ACCESS;
                  sel_d   = N_SLV'(1) << dec_idx;
                  we_d    = up.we_i ? (N_SLV'(1) << dec_idx) : '0;
                  addr_d  = up.addr_i;
                  wdata_d = up.wdata_i;
                  idx_d   = dec_idx;
                  wr_d    = up.we_i;
`ifdef BUS_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  // Errored request never reaches a slave
                  state_d = ST_RESP;
                  ready_d = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         ST_ACCESS: begin
            if (dn.ready_i[idx_q]) begin
               state_d = ST_RESP;
               sel_d   = '0;
               we_d    = '0;
               ready_d = 1'b1;
               rdata_d = wr_q ? '0 : dn.rdata_i[idx_q*DATA_W +: DATA_W];
            end
`ifdef BUS_TIMEOUT_EN
            else if (cnt_q == CNT_MAX) begin
               // Slave never answered: abort with an error response
               state_d = ST_RESP;
               sel_d   = '0;
               we_d    = '0;
               ready_d = 1'b1;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
`endif
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         we_q    <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
`ifdef BUS_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign up.rdata_o  = rdata_q;
   assign up.ready_o  = ready_q;
   assign up.err_o    = err_q;
   assign dn.sel_o    = sel_q;
   assign dn.we_o     = we_q;
   assign dn.addr_o   = addr_q;
   assign dn.wdata_o  = wdata_q;

endmodule
